// File: rtl/ntt_alu_pkg.sv
// Shared types and helpers for the NTT ALU front-end blocks.
package ntt_alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int barrett_r_width(input int logq);
    return logq + 1;
  endfunction

endpackage

// File: rtl/barrett_r_gen_div_step.sv
// One restoring-division step: compare the shifted partial remainder with q and subtract when possible.
module restoring_div_step #(
  parameter int W = 17
) (
  input  logic [W+1:0] i_t,
  input  logic [W-1:0] i_q,
  output logic [W:0]   o_rem_next,
  output logic         o_qbit
);

  logic [W:0] w_diff;

  // When t >= q we have t < 2q, so t - q always fits in W+1 bits.
  assign w_diff     = i_t[W:0] - {1'b0, i_q};
  assign o_qbit     = (i_t >= {2'b00, i_q});
  assign o_rem_next = o_qbit ? w_diff : i_t[W:0];

endmodule

// File: rtl/barrett_r_gen.sv
// Barrett constant generator: r = floor(2^(2*logq) / q) via a bit-serial restoring divider.
module barrett_r_gen
  import ntt_alu_pkg::*;
#(
  parameter int logq = 17
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [logq-1:0] q_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [logq-1:0] q_out,
  output logic [logq:0]   r_out,
  output logic            err
);

  localparam int RW     = barrett_r_width(logq);
  localparam int N_ITER = 2 * logq + 1;
  localparam int CW     = $clog2(N_ITER);
  localparam logic [CW-1:0]   CNT_LAST = CW'(N_ITER - 1);
  localparam logic [logq-1:0] Q_MIN    = {1'b1, {(logq-1){1'b0}}};

  state_t          r_state;
  state_t          w_state_next;
  logic [logq-1:0] r_q;
  logic [RW-1:0]   r_rem;
  logic [RW-1:0]   r_quot;
  logic [RW-1:0]   r_r;
  logic [CW-1:0]   r_cnt;
  logic            r_ovf;
  logic            r_err;
  logic            r_out_valid;

  logic            w_bit;
  logic [RW:0]     w_t;
  logic [RW-1:0]   w_rem_next;
  logic            w_qbit;
  logic            w_last;
  logic            w_err_final;

  // The dividend 2^(2*logq) has a single leading one, fed on the first step only.
  assign w_bit       = (r_cnt == '0);
  assign w_t         = {r_rem, w_bit};
  assign w_last      = (r_cnt == CNT_LAST);
  assign w_err_final = r_ovf | (r_q == '0) | (r_q <= Q_MIN);

  restoring_div_step #(
    .W(logq)
  ) u_step (
    .i_t        (w_t),
    .i_q        (r_q),
    .o_rem_next (w_rem_next),
    .o_qbit     (w_qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (in_valid) w_state_next = (q_in == '0) ? DONE : DIV;
      DIV:  if (w_last) w_state_next = DONE;
      DONE: if (r_out_valid && out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q         <= '0;
      r_rem       <= '0;
      r_quot      <= '0;
      r_r         <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_q    <= q_in;
            r_rem  <= '0;
            r_quot <= '0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
          end
        end
        DIV: begin
          r_rem  <= w_rem_next;
          r_quot <= {r_quot[RW-2:0], w_qbit};
          if (r_quot[RW-1]) r_ovf <= 1'b1;
          r_cnt  <= r_cnt + 1'b1;
        end
        DONE: begin
          // Result registers are loaded once on entry and then frozen until accepted.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_err       <= w_err_final;
            r_r         <= w_err_final ? '1 : r_quot;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = rst_n && (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign q_out     = r_q;
  assign r_out     = r_r;
  assign err       = r_err;

endmodule

// File: tb/tb_barrett_r_gen.sv
// Directed self-checking bench for barrett_r_gen (logq=17 and logq=14 instances).
module tb_barrett_r_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [16:0] q_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [16:0] q_out;
  logic [17:0] r_out;
  logic        err;

  logic        in_valid14 = 1'b0;
  logic        in_ready14;
  logic [13:0] q_in14 = '0;
  logic        out_valid14;
  logic        out_ready14 = 1'b0;
  logic [13:0] q_out14;
  logic [14:0] r_out14;
  logic        err14;

  int checks = 0;
  int failures = 0;
  int edges;

  always #5 clk = ~clk;

  barrett_r_gen #(.logq(17)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .q_in(q_in),
    .out_valid(out_valid), .out_ready(out_ready), .q_out(q_out), .r_out(r_out), .err(err)
  );

  barrett_r_gen #(.logq(14)) dut14 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid14), .in_ready(in_ready14), .q_in(q_in14),
    .out_valid(out_valid14), .out_ready(out_ready14), .q_out(q_out14), .r_out(r_out14), .err(err14)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic request17(input logic [16:0] q, output int n);
    @(negedge clk);
    in_valid = 1'b1;
    q_in     = q;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic handshake17();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hs_out_valid_low", 32'(out_valid), 32'd0);
    check("hs_in_ready_high", 32'(in_ready), 32'd1);
  endtask

  initial begin
    // Reset state
    #3 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_r_out", 32'(r_out), 32'd0);
    check("rst_q_out", 32'(q_out), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready_after", 32'(in_ready), 32'd1);
    $display("step reset: in_ready=%0d out_valid=%0d", in_ready, out_valid);

    // q = 65537
    request17(17'd65537, edges);
    check("t1_latency", 32'(edges), 32'd36);
    check("t1_r_out", 32'(r_out), 32'd262140);
    check("t1_q_out", 32'(q_out), 32'd65537);
    check("t1_err", 32'(err), 32'd0);
    $display("txn q=65537 r=%0d err=%0d edges=%0d", r_out, err, edges);
    handshake17();

    // q = 2^17-1
    request17(17'd131071, edges);
    check("t2_latency", 32'(edges), 32'd36);
    check("t2_r_out", 32'(r_out), 32'd131073);
    check("t2_err", 32'(err), 32'd0);
    $display("txn q=131071 r=%0d err=%0d edges=%0d", r_out, err, edges);
    handshake17();

    // logq=14, q = 12289
    @(negedge clk);
    in_valid14 = 1'b1;
    q_in14     = 14'd12289;
    @(posedge clk); #1;
    in_valid14 = 1'b0;
    edges = 0;
    while (!out_valid14 && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
    check("t3_latency", 32'(edges), 32'd30);
    check("t3_r_out", 32'(r_out14), 32'd21843);
    check("t3_q_out", 32'(q_out14), 32'd12289);
    check("t3_err", 32'(err14), 32'd0);
    $display("txn logq=14 q=12289 r=%0d err=%0d edges=%0d", r_out14, err14, edges);
    out_ready14 = 1'b1;
    @(posedge clk); #1;
    out_ready14 = 1'b0;
    check("t3_hs_out_valid_low", 32'(out_valid14), 32'd0);

    // q = 2^16: r would not fit
    request17(17'd65536, edges);
    check("t4a_latency", 32'(edges), 32'd36);
    check("t4a_err", 32'(err), 32'd1);
    check("t4a_r_out", 32'(r_out), 32'd262143);
    $display("txn q=65536 r=%0d err=%0d edges=%0d", r_out, err, edges);
    handshake17();

    // q = 0: fast error path
    request17(17'd0, edges);
    check("t4b_latency", 32'(edges), 32'd1);
    check("t4b_err", 32'(err), 32'd1);
    check("t4b_r_out", 32'(r_out), 32'd262143);
    $display("txn q=0 r=%0d err=%0d edges=%0d", r_out, err, edges);
    handshake17();

    // Backpressure with ignored in_valid pulses
    request17(17'd65537, edges);
    check("t5_latency", 32'(edges), 32'd36);
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      q_in     = 17'd3;
      @(posedge clk); #1;
      check("t5_hold_out_valid", 32'(out_valid), 32'd1);
      check("t5_hold_r_out", 32'(r_out), 32'd262140);
      check("t5_hold_q_out", 32'(q_out), 32'd65537);
      check("t5_hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    $display("txn backpressure q=65537 r=%0d held 10 cycles", r_out);
    handshake17();
    request17(17'd131071, edges);
    check("t5_next_r_out", 32'(r_out), 32'd131073);
    check("t5_next_q_out", 32'(q_out), 32'd131071);
    $display("txn q=131071 after backpressure r=%0d err=%0d", r_out, err);
    handshake17();

    // Asynchronous reset mid-division
    @(negedge clk);
    in_valid = 1'b1;
    q_in     = 17'd65537;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t6_rst_out_valid", 32'(out_valid), 32'd0);
    check("t6_rst_r_out", 32'(r_out), 32'd0);
    check("t6_rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t6_in_ready_after", 32'(in_ready), 32'd1);
    request17(17'd65537, edges);
    check("t6_latency", 32'(edges), 32'd36);
    check("t6_r_out", 32'(r_out), 32'd262140);
    check("t6_err", 32'(err), 32'd0);
    $display("txn after reset q=65537 r=%0d err=%0d edges=%0d", r_out, err, edges);
    handshake17();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
